controle_varredura_matriz: RTL and testbench

Scan controller for the 5x7 LED matrix display. It generates the 3-bit row counter that drives the combinational pattern decoders ("quadros"), selects which decoder's 5 column bits reach the matrix pins, and drives the one-hot row enables. The pattern can be chosen manually or rotated automatically. Pattern changes take effect only at frame boundaries, with a one-row blanking slot in between.

---
 rtl/controle_varredura_matriz_pkg.sv | 13 +
 rtl/divisor_varredura.sv | 30 +++
 rtl/controle_varredura_matriz.sv | 124 ++++++++++++
 tb/tb_controle_varredura_matriz.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/controle_varredura_matriz_pkg.sv
// Shared definitions for the LED matrix scan controller.
//   estado_t        : scan FSM state encoding (VARRE = scanning, APAGA = blanking slot)
//   LARGURA_COLUNAS : column bits per pattern decoder
package controle_varredura_matriz_pkg;

   typedef enum logic {
      VARRE = 1'b0,
      APAGA = 1'b1
   } estado_t;

   localparam int unsigned LARGURA_COLUNAS = 5;

endpackage

// File: rtl/divisor_varredura.sv
// Prescaler: free-running counter 0..DIV-1 that wraps and flags the last count.
// Ports:
//   clk  : system clock
//   rst  : asynchronous, active-high reset (counter back to 0)
//   tick : high for one clk while the counter sits at DIV-1
module divisor_varredura #(
   parameter int unsigned DIV = 1000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int unsigned LARGURA = $clog2(DIV);

   logic [LARGURA-1:0] contagem;

   assign tick = (contagem == LARGURA'(DIV - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         contagem <= '0;
      end else if (tick) begin
         contagem <= '0;
      end else begin
         contagem <= contagem + 1'b1;
      end
   end

endmodule

// File: rtl/controle_varredura_matriz.sv
// Scan controller for a 5x7 LED matrix. Walks the row counter, drives one-hot row
// enables, muxes the selected pattern decoder onto the columns and switches patterns
// only at frame boundaries, inserting one blank row slot on every change.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   modo_auto       : 1 = rotate patterns every FRAMES_AUTO frames, 0 = follow sel_quadro
//   sel_quadro      : requested pattern in manual mode (clamped to NUM_QUADROS-1)
//   quadros_colunas : concatenated decoder outputs, quadro k at [5k+4:5k]
//   contador        : row index fed to the decoders
//   linhas          : one-hot row enable (all zero while blanking)
//   colunas         : column drive (all zero while blanking)
//   quadro_ativo    : pattern being displayed
//   fim_quadro      : one-clk pulse per completed frame
module controle_varredura_matriz
   import controle_varredura_matriz_pkg::*;
#(
   parameter int unsigned DIV         = 1000,
   parameter int unsigned NUM_LINHAS  = 7,
   parameter int unsigned NUM_QUADROS = 4,
   parameter int unsigned FRAMES_AUTO = 50
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   modo_auto,
   input  logic [1:0]                             sel_quadro,
   input  logic [LARGURA_COLUNAS*NUM_QUADROS-1:0] quadros_colunas,
   output logic [2:0]                             contador,
   output logic [NUM_LINHAS-1:0]                  linhas,
   output logic [LARGURA_COLUNAS-1:0]             colunas,
   output logic [1:0]                             quadro_ativo,
   output logic                                   fim_quadro
);

   localparam int unsigned LARGURA_FRAMES = $clog2(FRAMES_AUTO + 1);
   localparam logic [2:0] ULTIMA_LINHA = 3'(NUM_LINHAS - 1);
   localparam logic [1:0] ULTIMO_QUADRO = 2'(NUM_QUADROS - 1);
   localparam logic [LARGURA_FRAMES-1:0] ULTIMO_FRAME = LARGURA_FRAMES'(FRAMES_AUTO - 1);

   estado_t                   estado;
   logic                      tick;
   logic [LARGURA_FRAMES-1:0] cont_frames;
   logic                      modo_auto_q;
   logic                      fim_rodizio;
   logic [1:0]                prox;

   divisor_varredura #(
      .DIV(DIV)
   ) u_divisor (
      .clk (clk),
      .rst (rst),
      .tick(tick)
   );

   // Pattern to show in the next frame; only consumed at a frame boundary.
   always_comb begin
      fim_rodizio = modo_auto && (cont_frames == ULTIMO_FRAME);
      if (modo_auto) begin
         if (fim_rodizio) begin
            prox = (quadro_ativo == ULTIMO_QUADRO) ? 2'd0 : quadro_ativo + 2'd1;
         end else begin
            prox = quadro_ativo;
         end
      end else begin
         prox = (sel_quadro > ULTIMO_QUADRO) ? ULTIMO_QUADRO : sel_quadro;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado       <= VARRE;
         contador     <= 3'd0;
         quadro_ativo <= 2'd0;
         cont_frames  <= '0;
         modo_auto_q  <= 1'b0;
         fim_quadro   <= 1'b0;
      end else begin
         fim_quadro  <= 1'b0;
         modo_auto_q <= modo_auto;
         if (tick) begin
            case (estado)
               VARRE: begin
                  if (contador == ULTIMA_LINHA) begin
                     fim_quadro <= 1'b1;
                     contador   <= 3'd0;
                     if (modo_auto) begin
                        cont_frames <= fim_rodizio ? '0 : cont_frames + 1'b1;
                     end
                     if (prox != quadro_ativo) begin
                        quadro_ativo <= prox;
                        estado       <= APAGA;
                     end
                  end else begin
                     contador <= contador + 3'd1;
                  end
               end
               APAGA: begin
                  estado   <= VARRE;
                  contador <= 3'd0;
               end
            endcase
         end
         // Frame count is only meaningful in auto mode and restarts on any mode change.
         if (!modo_auto || (modo_auto != modo_auto_q)) begin
            cont_frames <= '0;
         end
      end
   end

   always_comb begin
      linhas  = '0;
      colunas = '0;
      if (estado == VARRE) begin
         for (int i = 0; i < NUM_LINHAS; i++) begin
            linhas[i] = (contador == 3'(i));
         end
         for (int k = 0; k < NUM_QUADROS; k++) begin
            if (quadro_ativo == 2'(k)) begin
               colunas = quadros_colunas[k*LARGURA_COLUNAS +: LARGURA_COLUNAS];
            end
         end
      end
   end

endmodule

// File: tb/tb_controle_varredura_matriz.sv
// Directed bench for the scan controller: DIV=4, 7 rows, FRAMES_AUTO=2.
// A second instance with NUM_QUADROS=3 shares all inputs to exercise clamping.
module tb_controle_varredura_matriz;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        modo_auto = 1'b0;
   logic [1:0]  sel_quadro = 2'd0;
   logic [19:0] quadros_colunas;

   logic [2:0]  contador, contador2;
   logic [6:0]  linhas, linhas2;
   logic [4:0]  colunas, colunas2;
   logic [1:0]  quadro_ativo, quadro_ativo2;
   logic        fim_quadro, fim_quadro2;

   int n_cmp = 0;
   int n_err = 0;

   // q3=1C, q2=13, q1=0A, q0=05
   assign quadros_colunas = {5'h1C, 5'h13, 5'h0A, 5'h05};

   always #5 clk = ~clk;

   controle_varredura_matriz #(
      .DIV(4), .NUM_LINHAS(7), .NUM_QUADROS(4), .FRAMES_AUTO(2)
   ) dut (
      .clk(clk), .rst(rst), .modo_auto(modo_auto), .sel_quadro(sel_quadro),
      .quadros_colunas(quadros_colunas), .contador(contador), .linhas(linhas),
      .colunas(colunas), .quadro_ativo(quadro_ativo), .fim_quadro(fim_quadro)
   );

   controle_varredura_matriz #(
      .DIV(4), .NUM_LINHAS(7), .NUM_QUADROS(3), .FRAMES_AUTO(2)
   ) dut3 (
      .clk(clk), .rst(rst), .modo_auto(modo_auto), .sel_quadro(sel_quadro),
      .quadros_colunas(quadros_colunas[14:0]), .contador(contador2), .linhas(linhas2),
      .colunas(colunas2), .quadro_ativo(quadro_ativo2), .fim_quadro(fim_quadro2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Returns 1 time unit after the n-th rising edge.
   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state
      wait_clk(2);
      chk("rst_contador", 32'(contador), 32'd0);
      chk("rst_linhas", 32'(linhas), 32'h01);
      chk("rst_colunas", 32'(colunas), 32'h05);
      chk("rst_quadro", 32'(quadro_ativo), 32'd0);
      chk("rst_fim", 32'(fim_quadro), 32'd0);

      // 1: row stepping every 4 clk, fim_quadro once per 28 clk
      @(negedge clk) rst = 1'b0;
      wait_clk(1);
      chk("t1_cont0", 32'(contador), 32'd0);
      for (int r = 1; r < 7; r++) begin
         wait_clk(4);
         chk("t1_cont", 32'(contador), 32'(r));
         chk("t1_linhas", 32'(linhas), 32'(1 << r));
         chk("t1_fim_lo", 32'(fim_quadro), 32'd0);
      end
      wait_clk(3);
      chk("t1_fim_hi", 32'(fim_quadro), 32'd1);
      // 6: unchanged selection -> straight from row 6 to row 0, no blanking
      chk("t6_cont_wrap", 32'(contador), 32'd0);
      chk("t6_linhas", 32'(linhas), 32'h01);
      chk("t6_colunas", 32'(colunas), 32'h05);
      wait_clk(1);
      chk("t1_fim_pulse", 32'(fim_quadro), 32'd0);
      wait_clk(3);
      chk("t6_cont1", 32'(contador), 32'd1);

      // 2: change 0->2 during row 3 of the second frame
      wait_clk(9);
      chk("t2_row3", 32'(contador), 32'd3);
      sel_quadro = 2'd2;
      #1;
      chk("t2_hold_q", 32'(quadro_ativo), 32'd0);
      chk("t2_hold_col", 32'(colunas), 32'h05);
      wait_clk(14);
      chk("t2_row6_q", 32'(quadro_ativo), 32'd0);
      chk("t2_row6_c", 32'(contador), 32'd6);
      wait_clk(1);
      chk("t2_apaga_q", 32'(quadro_ativo), 32'd2);
      chk("t2_apaga_lin", 32'(linhas), 32'd0);
      chk("t2_apaga_col", 32'(colunas), 32'd0);
      chk("t2_apaga_fim", 32'(fim_quadro), 32'd1);
      chk("t2_apaga_cnt", 32'(contador), 32'd0);
      wait_clk(1);
      chk("t2_apaga_fim0", 32'(fim_quadro), 32'd0);
      wait_clk(2);
      chk("t2_apaga_end", 32'(linhas), 32'd0);
      wait_clk(1);
      chk("t2_varre_lin", 32'(linhas), 32'h01);
      chk("t2_varre_col", 32'(colunas), 32'h13);
      chk("t2_varre_cnt", 32'(contador), 32'd0);

      // 5a: reset during blanking
      wait_clk(1);
      sel_quadro = 2'd1;
      wait_clk(28);
      chk("t5_in_apaga", 32'(linhas), 32'd0);
      chk("t5_in_apaga_q", 32'(quadro_ativo), 32'd1);
      rst = 1'b1;
      #1;
      chk("t5a_cont", 32'(contador), 32'd0);
      chk("t5a_quadro", 32'(quadro_ativo), 32'd0);
      chk("t5a_linhas", 32'(linhas), 32'h01);
      chk("t5a_colunas", 32'(colunas), 32'h05);
      chk("t5a_fim", 32'(fim_quadro), 32'd0);
      sel_quadro = 2'd0;
      wait_clk(2);
      chk("t5a_hold", 32'(contador), 32'd0);

      // 5b: reset at row 5
      @(negedge clk) rst = 1'b0;
      wait_clk(22);
      chk("t5b_row5", 32'(contador), 32'd5);
      rst = 1'b1;
      #1;
      chk("t5b_cont", 32'(contador), 32'd0);
      chk("t5b_linhas", 32'(linhas), 32'h01);
      wait_clk(8);
      chk("t5b_no_fim", 32'(fim_quadro), 32'd0);
      chk("t5b_cont_held", 32'(contador), 32'd0);

      // 4: sel_quadro=3 clamps to 2 on the 3-pattern instance
      sel_quadro = 2'd3;
      @(negedge clk) rst = 1'b0;
      wait_clk(27);
      chk("t4_pre_q4", 32'(quadro_ativo), 32'd0);
      chk("t4_pre_q3", 32'(quadro_ativo2), 32'd0);
      wait_clk(1);
      chk("t4_q4", 32'(quadro_ativo), 32'd3);
      chk("t4_q3_clamp", 32'(quadro_ativo2), 32'd2);
      chk("t4_blank", 32'(linhas2), 32'd0);
      wait_clk(4);
      chk("t4_col4", 32'(colunas), 32'h1C);
      chk("t4_col3", 32'(colunas2), 32'h13);
      chk("t4_lin3", 32'(linhas2), 32'h01);

      // 3: auto rotation every 2 frames plus one blank slot, wrapping 3->0
      rst = 1'b1;
      modo_auto = 1'b1;
      sel_quadro = 2'd0;
      wait_clk(2);
      @(negedge clk) rst = 1'b0;
      wait_clk(28);
      chk("t3_f1_fim", 32'(fim_quadro), 32'd1);
      chk("t3_f1_q", 32'(quadro_ativo), 32'd0);
      chk("t3_f1_lin", 32'(linhas), 32'h01);
      wait_clk(27);
      for (int j = 0; j < 4; j++) begin
         chk("t3_before", 32'(quadro_ativo), 32'(j));
         wait_clk(1);
         chk("t3_after", 32'(quadro_ativo), 32'((j + 1) % 4));
         chk("t3_blank", 32'(linhas), 32'd0);
         wait_clk(59);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
